// File: rtl/lsu_req.sv
// lsu_req: MEM-stage load/store initiator. Turns one pipeline memory
// operation into a single req/ack transaction on the data bus. It lane-shifts
// store data, extracts and extends load data, stalls the pipeline while the
// access is in flight, and reports misaligned accesses and bus timeouts.
module lsu_req #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [2:0]  ls_type,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        addr_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Access size encoding used internally
    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;

    // Attributes of the access in flight, captured at issue
    logic [1:0]  size_reg;
    logic [1:0]  off_reg;
    logic        sext_reg;
    logic        we_reg;

    // Registered bus side and result outputs
    logic        bus_req_reg;
    logic        bus_we_reg;
    logic [31:0] bus_addr_reg;
    logic [3:0]  bus_be_reg;
    logic [31:0] bus_wdata_reg;
    logic [31:0] load_data_reg;
    logic        load_valid_reg;
    logic        bus_err_reg;

    // Decode of the incoming operation
    logic [1:0]  size_in;
    logic        sext_in;
    logic        misaligned;
    logic        issue;
    logic        timeout_hit;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    // Load result path
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] ext_data;

    // Decode ls_type into access size and signedness; unused codes act as word
    always_comb begin
        size_in = SZ_WORD;
        sext_in = 1'b0;
        case (ls_type)
            3'b001: begin size_in = SZ_HALF; sext_in = 1'b1; end
            3'b010: begin size_in = SZ_HALF; sext_in = 1'b0; end
            3'b011: begin size_in = SZ_BYTE; sext_in = 1'b1; end
            3'b100: begin size_in = SZ_BYTE; sext_in = 1'b0; end
            default: ;
        endcase
    end

    assign misaligned  = ((size_in == SZ_WORD) && (mem_addr[1:0] != 2'b00)) ||
                         ((size_in == SZ_HALF) && mem_addr[0]);
    assign issue       = (state_reg == IDLE) && mem_valid && !misaligned;
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // Per-lane store byte enable and replicated store data
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign st_be[gi] = (size_in == SZ_WORD) ||
                               ((size_in == SZ_HALF) && (mem_addr[1] == (gi >= 2))) ||
                               ((size_in == SZ_BYTE) && (mem_addr[1:0] == 2'(gi)));
            assign st_wdata[8*gi +: 8] = (size_in == SZ_WORD) ? mem_wdata[8*gi +: 8] :
                                         (size_in == SZ_HALF) ? mem_wdata[8*(gi%2) +: 8] :
                                                                mem_wdata[7:0];
        end
    endgenerate

    // Select the addressed lane of the read word and extend it
    always_comb begin
        half_sel = off_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (off_reg)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        case (size_reg)
            SZ_HALF: ext_data = {{16{sext_reg & half_sel[15]}}, half_sel};
            SZ_BYTE: ext_data = {{24{sext_reg & byte_sel[7]}}, byte_sel};
            default: ext_data = bus_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic: DONE lasts one cycle so the finishing op is never re-issued
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (issue) state_next = REQ;
            REQ:     if (bus_ack || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus drive, timeout counter, load capture and completion pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= '0;
            size_reg       <= SZ_WORD;
            off_reg        <= 2'b00;
            sext_reg       <= 1'b0;
            we_reg         <= 1'b0;
            bus_req_reg    <= 1'b0;
            bus_we_reg     <= 1'b0;
            bus_addr_reg   <= '0;
            bus_be_reg     <= '0;
            bus_wdata_reg  <= '0;
            load_data_reg  <= '0;
            load_valid_reg <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            load_valid_reg <= 1'b0;
            bus_err_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        cnt_reg       <= '0;
                        size_reg      <= size_in;
                        off_reg       <= mem_addr[1:0];
                        sext_reg      <= sext_in;
                        we_reg        <= mem_we;
                        bus_req_reg   <= 1'b1;
                        bus_we_reg    <= mem_we;
                        bus_addr_reg  <= {mem_addr[31:2], 2'b00};
                        bus_be_reg    <= mem_we ? st_be : 4'hF;
                        bus_wdata_reg <= mem_we ? st_wdata : 32'h0;
                    end
                end
                REQ: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (bus_ack) begin
                        bus_req_reg <= 1'b0;
                        bus_we_reg  <= 1'b0;
                        if (!we_reg) begin
                            load_data_reg  <= ext_data;
                            load_valid_reg <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        bus_req_reg   <= 1'b0;
                        bus_we_reg    <= 1'b0;
                        load_data_reg <= '0;
                        bus_err_reg   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_req    = bus_req_reg;
    assign bus_we     = bus_we_reg;
    assign bus_addr   = bus_addr_reg;
    assign bus_be     = bus_be_reg;
    assign bus_wdata  = bus_wdata_reg;
    assign load_data  = load_data_reg;
    assign load_valid = load_valid_reg;
    assign bus_err    = bus_err_reg;
    assign stall      = !reset && (issue || (state_reg == REQ));
    assign addr_err   = !reset && (state_reg == IDLE) && mem_valid && misaligned;

endmodule

// File: tb/tb_lsu_req.sv
// tb_lsu_req: directed and randomized checks of lsu_req against a
// behavioural model of the load/store rules.
module tb_lsu_req;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_we;
    logic [2:0]  ls_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        addr_err;
    logic        bus_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_ld = 32'h0;

    lsu_req #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_we(mem_we),
        .ls_type(ls_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] t);
        if (t == 3'd1 || t == 3'd2) return 2;
        if (t == 3'd3 || t == 3'd4) return 1;
        return 4;
    endfunction

    function automatic bit m_mis(input logic [2:0] t, input logic [31:0] a);
        int sz;
        sz = m_size(t);
        return (sz == 4 && a[1:0] != 2'b00) || (sz == 2 && a[0]);
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] t, input logic [31:0] a);
        int sz;
        int v;
        sz = m_size(t);
        v = ((1 << sz) - 1) << a[1:0];
        return we ? v[3:0] : 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] wd);
        logic [31:0] w;
        int sz;
        sz = m_size(t);
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
        int sz;
        int off;
        logic [63:0] mask;
        logic [31:0] v;
        sz   = m_size(t);
        off  = (sz == 4) ? 0 : int'(a[1:0]);
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = (rd >> (8 * off)) & mask[31:0];
        if ((t == 3'd1 || t == 3'd3) && v[8*sz-1]) v = v | ~mask[31:0];
        return v;
    endfunction

    // ---------------- stimulus driver ----------------
    // Presents one op starting at a negedge, acks after 'delay' REQ cycles
    // (never if delay is large), and records what the DUT did.
    task automatic run_op(input logic we, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int delay,
                          output int stall_n, output int req_n, output int lv_n,
                          output int be_n, output int ae_n,
                          output logic [31:0] o_addr, output logic [31:0] o_wdata,
                          output logic [31:0] o_ld, output logic [3:0] o_be,
                          output logic o_we, output logic o_stable);
        int cyc;
        bit fin;
        bit first;
        stall_n = 0; req_n = 0; lv_n = 0; be_n = 0; ae_n = 0;
        o_addr = 'x; o_wdata = 'x; o_be = 'x; o_we = 'x; o_stable = 1'b1;
        fin = 0; first = 1; cyc = 0;
        mem_valid = 1'b1; mem_we = we; ls_type = t; mem_addr = a; mem_wdata = wd;
        bus_rdata = rd; bus_ack = 1'b0;
        while (!fin && cyc < 64) begin
            #1;
            bus_ack = 1'b0;
            if (bus_req === 1'b1) begin
                if (first) begin
                    o_addr = bus_addr; o_wdata = bus_wdata; o_be = bus_be; o_we = bus_we;
                end else if ({bus_addr, bus_wdata, bus_be, bus_we} !== {o_addr, o_wdata, o_be, o_we}) begin
                    o_stable = 1'b0;
                end
                first = 0;
                if (req_n == delay) bus_ack = 1'b1;
                req_n++;
            end
            #1;
            if (stall === 1'b1) stall_n++; else fin = 1;
            if (addr_err === 1'b1) ae_n++;
            if (load_valid === 1'b1) lv_n++;
            if (bus_err === 1'b1) be_n++;
            @(negedge clk);
            cyc++;
        end
        mem_valid = 1'b0;
        bus_ack = 1'b0;
        repeat (2) begin
            #2;
            if (bus_req === 1'b1) req_n++;
            if (addr_err === 1'b1) ae_n++;
            if (load_valid === 1'b1) lv_n++;
            if (bus_err === 1'b1) be_n++;
            @(negedge clk);
        end
        o_ld = load_data;
        $display("op we=%0d type=%0d addr=%h delay=%0d: req=%0d stall=%0d lv=%0d berr=%0d aerr=%0d ld=%h",
                 we, t, a, delay, req_n, stall_n, lv_n, be_n, ae_n, o_ld);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; mem_valid = 1'b1; mem_we = 1'b0; ls_type = 3'd0;
        mem_addr = 32'h20; mem_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h5A5A1234;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, load_data, load_valid, addr_err, bus_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b we=%b be=%h addr=%h wd=%h ld=%h lv=%b ae=%b be=%b, required all 0",
                     bus_req, bus_we, bus_be, bus_addr, bus_wdata, load_data, load_valid, addr_err, bus_err);
        end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL release_stall: got %b want 1", stall); end
        @(negedge clk);
        #1;
        checks++;
        if ({bus_req, bus_addr, bus_be, bus_we} !== {1'b1, 32'h20, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL release_req: req=%b addr=%h be=%h we=%b want 1 00000020 f 0", bus_req, bus_addr, bus_be, bus_we);
        end
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checks++;
        if ({load_valid, load_data, stall} !== {1'b1, 32'h5A5A1234, 1'b0}) begin
            errors++;
            $display("FAIL release_done: lv=%b ld=%h stall=%b want 1 5a5a1234 0", load_valid, load_data, stall);
        end
        exp_ld = 32'h5A5A1234;
        mem_valid = 1'b0;
        @(negedge clk);
        $display("op reset-release lw 0x20 complete");
    endtask

    task automatic test_load_word();
        int sn, rn, lv, be, ae;
        logic [31:0] oa, ow, ol;
        logic [3:0] ob;
        logic owe, ost;
        run_op(1'b0, 3'd0, 32'h10, 32'h0, 32'h8000FFFF, 2, sn, rn, lv, be, ae, oa, ow, ol, ob, owe, ost);
        exp_ld = 32'h8000FFFF;
        checks++; if (oa !== 32'h10) begin errors++; $display("FAIL lw_addr: got %h want 00000010", oa); end
        checks++; if ({ob, owe} !== {4'hF, 1'b0}) begin errors++; $display("FAIL lw_be_we: got %h/%b want f/0", ob, owe); end
        checks++; if (ol !== exp_ld) begin errors++; $display("FAIL lw_data: got %h want %h", ol, exp_ld); end
        checks++; if (lv !== 1) begin errors++; $display("FAIL lw_valid_pulses: got %0d want 1", lv); end
        checks++; if (sn !== 4) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 4", sn); end
        checks++; if (ost !== 1'b1) begin errors++; $display("FAIL lw_stable: got %b want 1", ost); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  tt [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] aa [4] = '{32'h12, 32'h12, 32'h13, 32'h13};
        logic [31:0] ee [4] = '{32'hFFFF80FF, 32'h000080FF, 32'hFFFFFF80, 32'h00000080};
        int sn, rn, lv, be, ae;
        logic [31:0] oa, ow, ol;
        logic [3:0] ob;
        logic owe, ost;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, tt[i], aa[i], 32'h0, 32'h80FF1234, 0, sn, rn, lv, be, ae, oa, ow, ol, ob, owe, ost);
            exp_ld = ee[i];
            checks++;
            if (ol !== ee[i] || lv !== 1) begin
                errors++;
                $display("FAIL load_ext type=%0d: got %h lv=%0d want %h lv=1", tt[i], ol, lv, ee[i]);
            end
            checks++;
            if (sn !== 2 || oa !== 32'h10) begin
                errors++;
                $display("FAIL load_ext_timing type=%0d: stall=%0d addr=%h want 2 00000010", tt[i], sn, oa);
            end
        end
    endtask

    task automatic test_store();
        logic [2:0]  tt [2] = '{3'd3, 3'd1};
        logic [31:0] aa [2] = '{32'h7, 32'h6};
        logic [31:0] wv [2] = '{32'hAB, 32'h1234};
        logic [3:0]  eb [2] = '{4'b1000, 4'b1100};
        logic [31:0] ew [2] = '{32'hABABABAB, 32'h12341234};
        int sn, rn, lv, be, ae;
        logic [31:0] oa, ow, ol;
        logic [3:0] ob;
        logic owe, ost;
        for (int i = 0; i < 2; i++) begin
            run_op(1'b1, tt[i], aa[i], wv[i], 32'hDEADBEEF, 1, sn, rn, lv, be, ae, oa, ow, ol, ob, owe, ost);
            checks++;
            if ({oa, ob, ow, owe} !== {32'h4, eb[i], ew[i], 1'b1}) begin
                errors++;
                $display("FAIL store type=%0d: addr=%h be=%b wd=%h we=%b want 00000004 %b %h 1",
                         tt[i], oa, ob, ow, owe, eb[i], ew[i]);
            end
            checks++;
            if (lv !== 0 || ol !== exp_ld || sn !== 3) begin
                errors++;
                $display("FAIL store_side type=%0d: lv=%0d ld=%h stall=%0d want 0 %h 3", tt[i], lv, ol, sn, exp_ld);
            end
        end
    endtask

    task automatic test_misaligned();
        logic        ww [2] = '{1'b0, 1'b1};
        logic [2:0]  tt [2] = '{3'd0, 3'd1};
        logic [31:0] aa [2] = '{32'h2, 32'h5};
        int sn, rn, lv, be, ae;
        logic [31:0] oa, ow, ol;
        logic [3:0] ob;
        logic owe, ost;
        for (int i = 0; i < 2; i++) begin
            run_op(ww[i], tt[i], aa[i], 32'h1234, 32'h0, 0, sn, rn, lv, be, ae, oa, ow, ol, ob, owe, ost);
            checks++;
            if (ae !== 1 || rn !== 0 || sn !== 0) begin
                errors++;
                $display("FAIL misaligned addr=%h: aerr=%0d req=%0d stall=%0d want 1 0 0", aa[i], ae, rn, sn);
            end
        end
    endtask

    task automatic test_timeout();
        int sn, rn, lv, be, ae;
        logic [31:0] oa, ow, ol;
        logic [3:0] ob;
        logic owe, ost;
        run_op(1'b0, 3'd0, 32'h80, 32'h0, 32'h11112222, 1000, sn, rn, lv, be, ae, oa, ow, ol, ob, owe, ost);
        exp_ld = 32'h0;
        checks++;
        if (rn !== 16 || sn !== 17) begin
            errors++;
            $display("FAIL timeout_len: req=%0d stall=%0d want 16 17", rn, sn);
        end
        checks++;
        if (be !== 1 || lv !== 0 || ol !== 32'h0) begin
            errors++;
            $display("FAIL timeout_err: berr=%0d lv=%0d ld=%h want 1 0 00000000", be, lv, ol);
        end
        // Ack in the last allowed REQ cycle beats the timeout
        run_op(1'b0, 3'd0, 32'h84, 32'h0, 32'h33334444, 15, sn, rn, lv, be, ae, oa, ow, ol, ob, owe, ost);
        exp_ld = 32'h33334444;
        checks++;
        if (rn !== 16 || be !== 0 || lv !== 1 || ol !== exp_ld) begin
            errors++;
            $display("FAIL ack_at_limit: req=%0d berr=%0d lv=%0d ld=%h want 16 0 1 %h", rn, be, lv, ol, exp_ld);
        end
    endtask

    task automatic test_reset_mid();
        int lvc;
        mem_valid = 1'b1; mem_we = 1'b0; ls_type = 3'd0; mem_addr = 32'h40;
        bus_ack = 1'b0; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b1) begin errors++; $display("FAIL mid_req_up: got %b want 1", bus_req); end
        reset = 1'b1;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus_req, stall} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_drop: req=%b stall=%b want 0 0", bus_req, stall);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_ack = 1'b1;
        lvc = 0;
        repeat (3) begin
            #1;
            if (load_valid === 1'b1 || bus_req === 1'b1) lvc++;
            @(negedge clk);
            bus_ack = 1'b0;
        end
        exp_ld = 32'h0;
        checks++;
        if (lvc !== 0 || load_data !== 32'h0) begin
            errors++;
            $display("FAIL late_ack: activity=%0d ld=%h want 0 00000000", lvc, load_data);
        end
        $display("op reset in REQ, late ack: activity=%0d", lvc);
    endtask

    task automatic test_back_to_back();
        int sn, rn, lv, be, ae;
        logic [31:0] oa, ow, ol;
        logic [3:0] ob;
        logic owe, ost;
        logic we;
        logic [2:0] t;
        logic [31:0] a, wd, rd;
        int d, exp_req;
        bit mis, to;
        for (int n = 0; n < 40; n++) begin
            we  = 1'($urandom_range(0, 1));
            t   = 3'($urandom_range(0, 4));
            a   = $urandom;
            wd  = $urandom;
            rd  = $urandom;
            d   = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
            run_op(we, t, a, wd, rd, d, sn, rn, lv, be, ae, oa, ow, ol, ob, owe, ost);
            mis = m_mis(t, a);
            to  = (d >= 16);
            if (mis) begin
                checks++;
                if (ae !== 1 || rn !== 0 || sn !== 0 || lv !== 0 || be !== 0) begin
                    errors++;
                    $display("FAIL rnd_mis #%0d: aerr=%0d req=%0d stall=%0d lv=%0d berr=%0d want 1 0 0 0 0",
                             n, ae, rn, sn, lv, be);
                end
            end else begin
                exp_req = to ? 16 : d + 1;
                if (to) exp_ld = 32'h0;
                else if (!we) exp_ld = m_load(t, a, rd);
                checks++;
                if ({oa, ob, owe} !== {a & 32'hFFFFFFFC, m_be(we, t, a), we}) begin
                    errors++;
                    $display("FAIL rnd_bus #%0d: addr=%h be=%b we=%b want %h %b %b",
                             n, oa, ob, owe, a & 32'hFFFFFFFC, m_be(we, t, a), we);
                end
                if (we) begin
                    checks++;
                    if (ow !== m_wdata(t, wd)) begin
                        errors++;
                        $display("FAIL rnd_wdata #%0d: got %h want %h", n, ow, m_wdata(t, wd));
                    end
                end
                checks++;
                if (rn !== exp_req || sn !== exp_req + 1 || ae !== 0 || ost !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_timing #%0d: req=%0d stall=%0d aerr=%0d stable=%b want %0d %0d 0 1",
                             n, rn, sn, ae, ost, exp_req, exp_req + 1);
                end
                checks++;
                if (lv !== int'(!to && !we) || be !== int'(to) || ol !== exp_ld) begin
                    errors++;
                    $display("FAIL rnd_result #%0d: lv=%0d berr=%0d ld=%h want %0d %0d %h",
                             n, lv, be, ol, int'(!to && !we), int'(to), exp_ld);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_ext();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time in case the DUT never releases the pipeline
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
